// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_ctrl_pkg: shared state encoding and default geometry for the  |
// | single-port SRAM controller.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sram_ctrl_pkg;

  localparam int c_data_w_def = 8;
  localparam int c_depth_def  = 256;
  localparam int c_addr_w_def = 8;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_resp_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_ctrl_resp_buf: one-entry read-response stage; passes sram_q   |
// | straight through and parks it in a hold register on backpressure.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sram_ctrl_resp_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] sram_q,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata
);

  logic              r_q_live;
  logic              r_hold_vld;
  logic [DATA_W-1:0] r_hold_data;

  // sram_q is only meaningful in the cycle after a read fire (r_q_live).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_live    <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_q_live <= rd_fire;
      if (r_q_live && !resp_ready) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= sram_q;
      end else if (r_hold_vld && resp_ready) begin
        r_hold_vld  <= 1'b0;
        r_hold_data <= '0;
      end
    end
  end

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    if (!reset) begin
      resp_valid = r_q_live | r_hold_vld;
      if (r_hold_vld) begin
        resp_rdata = r_hold_data;
      end else if (r_q_live) begin
        resp_rdata = sram_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_port_ctrl: valid/ready front end for a single-port SRAM macro |
// | with optional zero-fill sweep after reset (SRAM_CTRL_INIT_EN).     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = c_data_w_def,
  parameter int DEPTH  = c_depth_def,
  parameter int ADDR_W = c_addr_w_def
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_fire;
  logic              w_rd_fire;
  logic              w_init_wr;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_resp_valid;

`ifdef SRAM_CTRL_INIT_EN
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_init_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_init_cnt <= '0;
    end else if (r_state == INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_init_addr = r_init_cnt;
    if (!reset && r_state == INIT) begin
      w_init_wr = 1'b1;
      if (r_init_cnt == c_last_addr) begin
        w_state_nxt = RUN;
      end
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_init_addr = '0;
  end
`endif

  // Backpressure stalls reads and writes alike so the response slot never overflows.
  assign req_ready = !reset && (r_state == RUN) && (!w_resp_valid || resp_ready);
  assign w_fire    = req_valid && req_ready;
  assign w_rd_fire = w_fire && !req_write;

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (w_fire) begin
      sram_ceb = 1'b0;
      sram_web = !req_write;
      sram_a   = req_addr;
      sram_d   = req_wdata;
    end else if (w_init_wr) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = w_init_addr;
    end
  end

  sram_ctrl_resp_buf #(
    .DATA_W (DATA_W)
  ) u_resp_buf (
    .clock      (clock),
    .reset      (reset),
    .rd_fire    (w_rd_fire),
    .sram_q     (sram_q),
    .resp_valid (w_resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata)
  );

  assign resp_valid = w_resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sram_port_ctrl: directed bench for sram_port_ctrl with a        |
// | behavioural single-port SRAM whose output is valid only after reads|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sram_port_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_ready = 1'b0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  logic          tb_fill = 1'b1;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;

  sram_port_ctrl #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_ceb   (sram_ceb),
    .sram_web   (sram_web),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  always #5 clock = ~clock;

  // Macro model: q carries data only in the cycle after a read, garbage otherwise.
  always @(posedge clock) begin
    if (tb_fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
      sram_q <= 8'hEE;
    end else begin
      if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
      else                       sram_q <= 8'hEE;
      if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'h33, 8'h44);
    resp_ready = 1'b0;
    tick;
    tick;
    tb_fill = 1'b0;
    @(negedge clock);
    total++;
    if ({req_ready, resp_valid, resp_rdata} !== {1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_resp got=%b exp=%b", {req_ready, resp_valid, resp_rdata}, {1'b0, 1'b0, 8'h00});
    end
    total++;
    if ({sram_ceb, sram_web, sram_a, sram_d} !== {1'b1, 1'b1, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_sram got=%h exp=%h", {sram_ceb, sram_web, sram_a, sram_d}, {1'b1, 1'b1, 8'h00, 8'h00});
    end
    tick;
    drive(1'b0, 1'b0, '0, '0);
  endtask

`ifdef SRAM_CTRL_INIT_EN
  task automatic test_init;
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      total++;
      if ({sram_ceb, sram_web, sram_a, sram_d, req_ready} !== {1'b0, 1'b0, 8'(i), 8'h00, 1'b0}) begin
        bad++;
        $display("FAIL init_sweep[%0d] got=%h exp=%h", i,
                 {sram_ceb, sram_web, sram_a, sram_d, req_ready}, {1'b0, 1'b0, 8'(i), 8'h00, 1'b0});
      end
      tick;
    end
    drive(1'b1, 1'b0, 8'h80, 8'h00);
    @(negedge clock);
    total++;
    if ({req_ready, sram_ceb, sram_web} !== 3'b101) begin
      bad++;
      $display("FAIL init_run_ready got=%b exp=%b", {req_ready, sram_ceb, sram_web}, 3'b101);
    end
    tick;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata} !== {1'b1, 8'h00}) begin
      bad++;
      $display("FAIL init_read80 got=%h exp=%h", {resp_valid, resp_rdata}, {1'b1, 8'h00});
    end
    tick;
  endtask

  task automatic test_init_restart;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    repeat (100) tick;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({sram_ceb, sram_a} !== {1'b1, 8'h00}) begin
      bad++;
      $display("FAIL restart_in_reset got=%h exp=%h", {sram_ceb, sram_a}, {1'b1, 8'h00});
    end
    tick;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({sram_ceb, sram_web, sram_a} !== {1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL restart_addr0 got=%h exp=%h", {sram_ceb, sram_web, sram_a}, {1'b0, 1'b0, 8'h00});
    end
    repeat (DEPTH) tick;
    @(negedge clock);
    total++;
    if ({req_ready, sram_ceb} !== 2'b11) begin
      bad++;
      $display("FAIL restart_run got=%b exp=%b", {req_ready, sram_ceb}, 2'b11);
    end
    tick;
  endtask
`else
  task automatic test_no_init;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({req_ready, sram_ceb} !== 2'b11) begin
      bad++;
      $display("FAIL noinit_first got=%b exp=%b", {req_ready, sram_ceb}, 2'b11);
    end
    tick;
    @(negedge clock);
    total++;
    if (sram_ceb !== 1'b1) begin
      bad++;
      $display("FAIL noinit_idle got=%b exp=%b", sram_ceb, 1'b1);
    end
    tick;
  endtask
`endif

  task automatic test_write_read;
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge clock);
    total++;
    if ({req_ready, sram_ceb, sram_web, sram_a, sram_d} !== {1'b1, 1'b0, 1'b0, 8'h10, 8'hA5}) begin
      bad++;
      $display("FAIL wr_issue got=%h exp=%h", {req_ready, sram_ceb, sram_web, sram_a, sram_d},
               {1'b1, 1'b0, 1'b0, 8'h10, 8'hA5});
    end
    tick;
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clock);
    total++;
    if ({resp_valid, sram_ceb, sram_web, sram_a} !== {1'b0, 1'b0, 1'b1, 8'h10}) begin
      bad++;
      $display("FAIL rd_issue got=%h exp=%h", {resp_valid, sram_ceb, sram_web, sram_a}, {1'b0, 1'b0, 1'b1, 8'h10});
    end
    tick;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL rd_after_wr got=%h exp=%h", {resp_valid, resp_rdata}, {1'b1, 8'hA5});
    end
    tick;
    @(negedge clock);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_single_resp got=%b exp=%b", resp_valid, 1'b0);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_d [3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'(i + 1), exp_d[i]);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 8'(i + 1), 8'h00);
      else       drive(1'b0, 1'b0, '0, '0);
      @(negedge clock);
      if (i < 3) begin
        total++;
        if (req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, req_ready, 1'b1);
        end
      end
      if (i > 0) begin
        total++;
        if ({resp_valid, resp_rdata} !== {1'b1, exp_d[i-1]}) begin
          bad++;
          $display("FAIL b2b_resp[%0d] got=%h exp=%h", i - 1, {resp_valid, resp_rdata}, {1'b1, exp_d[i-1]});
        end
      end
      tick;
    end
    @(negedge clock);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%b exp=%b", resp_valid, 1'b0);
    end
    tick;
  endtask

  task automatic test_backpressure;
    resp_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h05, 8'h5A);
    tick;
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h05, 8'h00);
    tick;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h06, 8'h00);
      @(negedge clock);
      total++;
      if ({resp_valid, resp_rdata, req_ready, sram_ceb} !== {1'b1, 8'h5A, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=%h exp=%h", k, {resp_valid, resp_rdata, req_ready, sram_ceb},
                 {1'b1, 8'h5A, 1'b0, 1'b1});
      end
      tick;
    end
    resp_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, req_ready} !== {1'b1, 8'h5A, 1'b1}) begin
      bad++;
      $display("FAIL bp_release got=%h exp=%h", {resp_valid, resp_rdata, req_ready}, {1'b1, 8'h5A, 1'b1});
    end
    tick;
    @(negedge clock);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_once got=%b exp=%b", resp_valid, 1'b0);
    end
    tick;
  endtask

  task automatic test_write_during_resp;
    resp_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    tick;
    drive(1'b1, 1'b1, 8'h20, 8'h3C);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, req_ready, sram_ceb, sram_web} !== {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL wr_with_resp got=%h exp=%h", {resp_valid, resp_rdata, req_ready, sram_ceb, sram_web},
               {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0});
    end
    tick;
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clock);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL wr_no_resp got=%b exp=%b", resp_valid, 1'b0);
    end
    tick;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata} !== {1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL wr_with_resp_read got=%h exp=%h", {resp_valid, resp_rdata}, {1'b1, 8'h3C});
    end
    tick;
  endtask

  task automatic test_reset_pending;
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h05, 8'h00);
    tick;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata} !== {1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL rstp_pending got=%h exp=%h", {resp_valid, resp_rdata}, {1'b1, 8'h5A});
    end
    tick;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({resp_valid, resp_rdata, req_ready} !== {1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL rstp_during got=%h exp=%h", {resp_valid, resp_rdata, req_ready}, {1'b0, 8'h00, 1'b0});
    end
    tick;
    reset = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    total++;
`ifdef SRAM_CTRL_INIT_EN
    if ({resp_valid, req_ready, sram_ceb, sram_a} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL rstp_after got=%h exp=%h", {resp_valid, req_ready, sram_ceb, sram_a}, {1'b0, 1'b0, 1'b0, 8'h00});
    end
`else
    if ({resp_valid, req_ready, sram_ceb} !== {1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL rstp_after got=%b exp=%b", {resp_valid, req_ready, sram_ceb}, {1'b0, 1'b1, 1'b1});
    end
`endif
    tick;
  endtask

  initial begin
    test_reset;
`ifdef SRAM_CTRL_INIT_EN
    test_init;
`else
    test_no_init;
`endif
    test_write_read;
    test_back_to_back;
    test_backpressure;
    test_write_during_resp;
    test_reset_pending;
`ifdef SRAM_CTRL_INIT_EN
    test_init_restart;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, SRAM word width.
REQ-002 SHALL have parameter DEPTH, default 256, SRAM word count.
REQ-003 SHALL have parameter ADDR_W, default 8, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1 (1=write), req_addr in ADDR_W, req_wdata in DATA_W; together they form the request channel.
REQ-007 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out DATA_W; together they form the read-response channel.
REQ-008 SHALL have ports sram_ceb out 1 (active-low enable), sram_web out 1 (active-low write), sram_a out ADDR_W, sram_d out DATA_W, and sram_q in DATA_W (macro output registered one cycle after the read).

Function
REQ-009 Request fire = req_valid & req_ready; sram_ceb SHALL be low only in a fire cycle or an init-write cycle.
REQ-010 On a fire cycle: sram_web = ~req_write, sram_a = req_addr, sram_d = req_wdata; on non-fire cycles: sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
REQ-011 req_ready SHALL be 1 iff state==RUN and (resp_valid==0 or resp_ready==1); the rule applies identically to reads and writes.
REQ-012 A read fired in cycle t SHALL give resp_valid=1 in cycle t+1, with resp_rdata=sram_q taken combinationally.
REQ-013 If resp_valid & ~resp_ready in the cycle sram_q is live, sram_q SHALL be captured into a hold register; resp_valid stays 1 and resp_rdata comes from the hold register until accepted.
REQ-014 Writes SHALL produce no response; a write and a response handshake in the same cycle are both legal.
REQ-015 Back-to-back reads with resp_ready=1 SHALL sustain one response per cycle, in issue order.
REQ-016 A read following a write to the same address in the next cycle SHALL return the new data; the controller relies on the macro's sequential order and adds no bypass.
REQ-017 At most one response SHALL be outstanding; sram_q SHALL never be sampled in a cycle that does not follow a read fire.
REQ-018 The state machine SHALL have states INIT and RUN: reset -> INIT if SRAM_CTRL_INIT_EN is defined, otherwise reset -> RUN; INIT -> RUN after the final init write.

Reset
REQ-019 While reset=1: req_ready=0, resp_valid=0, resp_rdata=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0; the hold register and init counter are cleared.
REQ-020 Reset asserted mid-operation SHALL drop any pending response and, with init enabled, restart the sweep at address 0.

Configuration
REQ-021 Macro SRAM_CTRL_INIT_EN defined: in INIT, the controller SHALL write 0 to addresses 0..DEPTH-1, one per cycle (sram_ceb=0, sram_web=0), with req_ready=0; RUN is entered the cycle after address DEPTH-1 is written, i.e. DEPTH cycles after reset deasserts.
REQ-022 Macro SRAM_CTRL_INIT_EN undefined: no INIT logic SHALL exist; req_ready may be 1 in the first cycle after reset deasserts.

Structure
REQ-023 Package sram_ctrl_pkg SHALL hold the state enum (INIT, RUN) and the default DATA_W/DEPTH/ADDR_W constants.
REQ-024 The one-entry response hold (REQ-012/013) SHALL be a sub-module, sram_ctrl_resp_buf.

Verification
REQ-025 Init enabled, DEPTH=256: release reset -> 256 cycles of ceb=0/web=0 at addresses 0..255 with d=0, then req_ready=1; a read of 0x80 returns 0x00.
REQ-026 Write 0xA5 to 0x10, then read 0x10 the next cycle -> resp_valid one cycle after the read, resp_rdata=0xA5.
REQ-027 Reads of 0x01, 0x02, 0x03 back-to-back with resp_ready=1 (holding 0x11, 0x22, 0x33) -> three consecutive responses 0x11, 0x22, 0x33 with no gap.
REQ-028 Read 0x05 (holding 0x5A) with resp_ready=0 for 4 cycles -> resp_rdata held at 0x5A, req_ready=0 and sram_ceb=1 throughout; release -> accepted once.
REQ-029 Assert reset for 1 cycle at init address 100 -> sweep restarts at 0; assert reset with a response pending -> resp_valid=0 the next cycle.
REQ-030 Init undefined: release reset -> req_ready=1 in the first cycle, with no write cycles issued.
